// File: rtl/pitch_detector.sv
// Measures the period of an asynchronous square wave and decodes it to the
// nearest MIDI note 12..96 (0 = no tone), committing only after a stable run.
module pitch_detector #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned MIN_PERIOD     = 45_000,
  parameter int unsigned MAX_PERIOD     = 6_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 8_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [7:0]  note,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [31:0] period
);

  localparam int NUM_NOTES  = 85;
  localparam int FIRST_NOTE = 12;
  localparam int STAB_W     = $clog2(STABLE_COUNT + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, SEARCH, COMMIT} state_t;

  // Equal-tempered period in clk cycles, evaluated at elaboration time.
  function automatic logic [31:0] note_period(input int n);
    real freq;
    freq = 440.0 * (2.0 ** (real'(n - 69) / 12.0));
    return 32'($rtoi(real'(CLK_HZ) / freq + 0.5));
  endfunction

  logic [31:0] period_rom [NUM_NOTES];

  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_rom
    assign period_rom[gi] = note_period(gi + FIRST_NOTE);
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], sig_in};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~sync_prev;

  state_t              state;
  logic [31:0]         cnt;
  logic [31:0]         meas;
  logic [6:0]          idx;
  logic [7:0]          best_note;
  logic [32:0]         best_diff;
  logic [7:0]          prev_cand;
  logic [STAB_W-1:0]   stab;
  logic [STAB_W-1:0]   stab_next;
  logic [32:0]         diff;
  logic [7:0]          cand;
  logic                in_range;

  always_comb begin
    if (meas >= period_rom[idx]) diff = {1'b0, meas} - {1'b0, period_rom[idx]};
    else                         diff = {1'b0, period_rom[idx]} - {1'b0, meas};
  end

  assign in_range = (meas >= MIN_PERIOD) && (meas <= MAX_PERIOD);
  assign cand     = in_range ? best_note : 8'd0;

  always_comb begin
    stab_next = STAB_W'(1);
    if (cand == prev_cand)
      stab_next = (stab >= STAB_W'(STABLE_COUNT)) ? stab : stab + STAB_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      meas        <= '0;
      idx         <= '0;
      best_note   <= '0;
      best_diff   <= '1;
      prev_cand   <= '0;
      stab        <= '0;
      note        <= '0;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
      period      <= '0;
    end else begin
      note_strobe <= 1'b0;
      // Counter keeps running through SEARCH/COMMIT and saturates at the timeout.
      if (state != IDLE && cnt != TIMEOUT_CYCLES)
        cnt <= cnt + 32'd1;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= 32'd1;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            meas      <= cnt;
            cnt       <= 32'd1;
            idx       <= '0;
            best_diff <= '1;
            best_note <= 8'(FIRST_NOTE);
            state     <= SEARCH;
          end else if (cnt >= TIMEOUT_CYCLES) begin
            note        <= '0;
            note_valid  <= 1'b0;
            note_strobe <= (note != 8'd0);
            stab        <= '0;
            prev_cand   <= '0;
            state       <= IDLE;
          end
        end
        SEARCH: begin
          if (rise) cnt <= 32'd1;
          // Strict less-than keeps the lower note on an exact tie.
          if (diff < best_diff) begin
            best_diff <= diff;
            best_note <= 8'(FIRST_NOTE) + 8'(idx);
          end
          if (idx == 7'(NUM_NOTES - 1)) state <= COMMIT;
          else                          idx   <= idx + 7'd1;
        end
        COMMIT: begin
          if (rise) cnt <= 32'd1;
          prev_cand <= cand;
          stab      <= stab_next;
          period    <= meas;
          if (stab_next == STAB_W'(STABLE_COUNT) && cand != note) begin
            note        <= cand;
            note_valid  <= (cand != 8'd0);
            note_strobe <= 1'b1;
          end
          state <= MEASURE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
